// File: rtl/median_binarize.sv
// Binarizes median-filtered grey pixels against a threshold. Defining MEAN_THRESH_EN
// adds an adaptive threshold equal to the previous frame's truncated mean pixel value.
module median_binarize #(
  parameter int         CNT_W      = 20,
  parameter logic [7:0] DEF_THRESH = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] iData,
  input  logic       i_de,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [7:0] oData,
  output logic       bin_de,
  output logic       bin_hs,
  output logic       bin_vs,
  output logic [7:0] thresh,
  output logic       busy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oData  <= 8'h00;
      bin_de <= 1'b0;
      bin_hs <= 1'b0;
      bin_vs <= 1'b0;
    end else begin
      oData  <= (i_de && (iData >= thresh)) ? 8'hFF : 8'h00;
      bin_de <= i_de;
      bin_hs <= i_hs;
      bin_vs <= i_vs;
    end
  end

`ifdef MEAN_THRESH_EN
  localparam int SUM_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;
  state_t state_reg, state_next;

  logic             vs_prev_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [SUM_W-1:0] rem_reg;
  logic [CNT_W-1:0] dcnt_reg;
  logic [7:0]       quot_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       thresh_reg;
  logic             frame_start;
  logic [SUM_W-1:0] trial;

  assign frame_start = i_vs & ~vs_prev_reg;
  // Divisor aligned to the quotient bit under test; sum <= 255*cnt keeps it in range.
  assign trial = {8'd0, dcnt_reg} << bit_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (frame_start) begin
      state_next = DIV;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        DIV:     if (bit_reg == 3'd0) state_next = LOAD;
        LOAD:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Accumulation runs regardless of divider state; the count saturates within a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_reg <= 1'b0;
      sum_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      vs_prev_reg <= i_vs;
      if (frame_start) begin
        sum_reg <= '0;
        cnt_reg <= '0;
      end else if (i_de && (cnt_reg != CNT_MAX)) begin
        sum_reg <= sum_reg + {{CNT_W{1'b0}}, iData};
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // A new frame boundary always restarts the division, which also aborts a pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg    <= '0;
      dcnt_reg   <= '0;
      quot_reg   <= 8'd0;
      bit_reg    <= 3'd7;
      thresh_reg <= DEF_THRESH;
    end else if (frame_start) begin
      rem_reg  <= sum_reg;
      dcnt_reg <= cnt_reg;
      quot_reg <= 8'd0;
      bit_reg  <= 3'd7;
    end else if (state_reg == DIV) begin
      if (rem_reg >= trial) begin
        rem_reg           <= rem_reg - trial;
        quot_reg[bit_reg] <= 1'b1;
      end
      bit_reg <= bit_reg - 3'd1;
    end else if ((state_reg == LOAD) && (dcnt_reg != '0)) begin
      thresh_reg <= quot_reg;
    end
  end

  assign thresh = thresh_reg;
  assign busy   = (state_reg != IDLE);
`else
  assign thresh = DEF_THRESH;
  assign busy   = 1'b0;
`endif

endmodule

// File: tb/tb_median_binarize.sv
// Randomized self-checking bench for median_binarize; the reference model keeps each
// frame's counted pixels in a queue and predicts the threshold as their integer mean.
module tb_median_binarize;
  localparam int CNT_W  = 4;
  localparam int MAXCNT = (1 << CNT_W) - 1;
`ifdef MEAN_THRESH_EN
  localparam logic BUSY_EXP = 1'b1;
`else
  localparam logic BUSY_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] iData = 8'd0;
  logic       i_de = 1'b0, i_hs = 1'b0, i_vs = 1'b0;
  logic [7:0] oData, thresh;
  logic       bin_de, bin_hs, bin_vs, busy;

  int checks = 0;
  int errors = 0;
  int unsigned frame_q[$];
  logic [7:0] exp_thresh = 8'd128;

  median_binarize #(.CNT_W(CNT_W), .DEF_THRESH(8'd128)) dut (
    .clk(clk), .rst_n(rst_n), .iData(iData), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
    .oData(oData), .bin_de(bin_de), .bin_hs(bin_hs), .bin_vs(bin_vs),
    .thresh(thresh), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel cycle: drive, let the model record it, then check the registered result.
  task automatic pixel(input string name, input logic de, input logic [7:0] d, input logic hs);
    logic [7:0] exp_o;
    i_de = de; iData = d; i_hs = hs; i_vs = 1'b0;
    exp_o = (de && (d >= exp_thresh)) ? 8'hFF : 8'h00;
    if (de && (frame_q.size() < MAXCNT)) frame_q.push_back(int'(d));
    tick();
    checks++;
    if (oData !== exp_o || bin_de !== de || bin_hs !== hs || bin_vs !== 1'b0) begin
      errors++;
      $display("FAIL %s: oData=%h de=%b hs=%b vs=%b, expected oData=%h de=%b hs=%b vs=0 (pix=%0d thr=%0d)",
               name, oData, bin_de, bin_hs, bin_vs, exp_o, de, hs, d, exp_thresh);
    end
  endtask

  function automatic logic [7:0] model_mean();
    int unsigned s;
    s = 0;
`ifdef MEAN_THRESH_EN
    if (frame_q.size() == 0) return exp_thresh;
    foreach (frame_q[i]) s += frame_q[i];
    return 8'(s / frame_q.size());
`else
    return 8'd128;
`endif
  endfunction

  // Frame boundary followed by the full divide window; thresh must not move until the end.
  task automatic boundary(input string name);
    logic [7:0] pend;
    pend = model_mean();
    frame_q.delete();
    i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (busy !== BUSY_EXP || thresh !== exp_thresh) begin
        errors++;
        $display("FAIL %s_window[%0d]: busy=%b thresh=%0d, expected busy=%b thresh=%0d",
                 name, k, busy, thresh, BUSY_EXP, exp_thresh);
      end
      tick();
    end
    exp_thresh = pend;
    checks++;
    if (busy !== 1'b0 || thresh !== exp_thresh) begin
      errors++;
      $display("FAIL %s_result: busy=%b thresh=%0d, expected busy=0 thresh=%0d",
               name, busy, thresh, exp_thresh);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (oData !== 8'h00 || bin_de !== 1'b0 || bin_hs !== 1'b0 || bin_vs !== 1'b0 ||
        busy !== 1'b0 || thresh !== 8'd128) begin
      errors++;
      $display("FAIL reset_state: oData=%h de=%b hs=%b vs=%b busy=%b thresh=%0d, expected 00 0 0 0 0 128",
               oData, bin_de, bin_hs, bin_vs, busy, thresh);
    end
    rst_n = 1'b1;
    pixel("pre_async", 1'b1, 8'd200, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (oData !== 8'h00 || bin_de !== 1'b0 || bin_hs !== 1'b0 || busy !== 1'b0 || thresh !== 8'd128) begin
      errors++;
      $display("FAIL async_reset: oData=%h de=%b hs=%b busy=%b thresh=%0d, expected 00 0 0 0 128",
               oData, bin_de, bin_hs, busy, thresh);
    end
    rst_n = 1'b1;
    frame_q.delete();
    exp_thresh = 8'd128;
  endtask

  task automatic test_fixed_threshold();
    pixel("fixed_127", 1'b1, 8'd127, 1'b0);
    pixel("fixed_128", 1'b1, 8'd128, 1'b0);
    pixel("de_low", 1'b0, 8'd255, 1'b0);
  endtask

  task automatic test_random_binarize();
    for (int i = 0; i < 40; i++)
      pixel("rand_bin", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    boundary("rand_bin_frame");
  endtask

  task automatic test_mean();
    boundary("mean_flush");
    for (int i = 0; i < 16; i++) pixel("mean_fill", 1'b1, 8'd60, 1'b0);
    boundary("mean60");
`ifdef MEAN_THRESH_EN
    checks++;
    if (thresh !== 8'd60) begin
      errors++;
      $display("FAIL mean60_value: thresh=%0d, expected 60", thresh);
    end
`endif
    pixel("mean_59", 1'b1, 8'd59, 1'b0);
    pixel("mean_60", 1'b1, 8'd60, 1'b0);
  endtask

  task automatic test_truncation();
    boundary("trunc_flush");
    pixel("trunc_10", 1'b1, 8'd10, 1'b0);
    pixel("trunc_11", 1'b1, 8'd11, 1'b0);
    boundary("trunc");
    boundary("empty");
`ifdef MEAN_THRESH_EN
    checks++;
    if (thresh !== 8'd10) begin
      errors++;
      $display("FAIL trunc_empty_value: thresh=%0d, expected 10", thresh);
    end
`endif
  endtask

  task automatic test_saturation();
    boundary("sat_flush");
    for (int i = 0; i < 20; i++) pixel("sat_fill", 1'b1, 8'($urandom), 1'b0);
    boundary("saturate");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        pixel("frame_pix", 1'b1, 8'($urandom), 1'b1);
        if ($urandom_range(0, 2) == 0) pixel("frame_gap", 1'b0, 8'($urandom), 1'b0);
      end
      boundary("rand_frame");
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) pixel("abort_a", 1'b1, 8'($urandom_range(200, 255)), 1'b0);
    frame_q.delete();
    i_de = 1'b0; i_vs = 1'b1;
    tick();
    checks++;
    if (busy !== BUSY_EXP) begin
      errors++;
      $display("FAIL abort_start: busy=%b, expected %b", busy, BUSY_EXP);
    end
    pixel("abort_b", 1'b1, 8'($urandom_range(0, 100)), 1'b0);
    pixel("abort_b", 1'b1, 8'($urandom_range(0, 100)), 1'b0);
    boundary("abort");
  endtask

  task automatic test_reset_mid_div();
    for (int i = 0; i < 4; i++) pixel("rdiv_a", 1'b1, 8'($urandom), 1'b0);
    i_de = 1'b0; i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || thresh !== 8'd128) begin
      errors++;
      $display("FAIL reset_mid_div: busy=%b thresh=%0d, expected 0 128", busy, thresh);
    end
    tick();
    rst_n = 1'b1;
    frame_q.delete();
    exp_thresh = 8'd128;
    for (int i = 0; i < 3; i++) pixel("rdiv_b", 1'b1, 8'($urandom), 1'b0);
    boundary("after_reset");
  endtask

  initial begin
    test_reset();
    test_fixed_threshold();
    test_random_binarize();
    test_mean();
    test_truncation();
    test_saturation();
    test_random_frames();
    test_abort();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
